// File: rtl/zsram_pkg.sv
// Shared types and defaults for the ZSRAM edge sequencer.
// ZSRAM_READBACK_VERIFY_EN adds the write-verify states to the state enum.
package zsram_pkg;

  localparam int ADDR_W            = 4;
  localparam int DEF_CELLS         = 12;
  localparam int DEF_STROBE_CYCLES = 2;
  localparam int DEF_SETTLE_CYCLES = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_SETTLE = 3'd3,
`ifdef ZSRAM_READBACK_VERIFY_EN
    ST_RESP    = 3'd4,
    ST_VSTROBE = 3'd5,
    ST_VSETTLE = 3'd6
`else
    ST_RESP    = 3'd4
`endif
  } state_e;

endpackage

// File: rtl/zsram_edge_decoder.sv
// Maps a cell address plus enable onto a one-hot strobe vector, all-zero when disabled.
module zsram_edge_decoder
  import zsram_pkg::*;
#(
  parameter int CELLS = DEF_CELLS
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_en,
  output logic [CELLS-1:0]  o_edge
);

  always_comb begin
    o_edge = '0;
    for (int i = 0; i < CELLS; i++) begin
      if (i_en && (i_addr == ADDR_W'(i))) o_edge[i] = 1'b1;
    end
  end

endmodule

// File: rtl/zsram_edge_sequencer.sv
// Request/response sequencer generating WriteEdge/ReadEdge strobes for a bank of ZSRAM cells.
// Define ZSRAM_READBACK_VERIFY_EN to read back and check every write before responding.
module zsram_edge_sequencer
  import zsram_pkg::*;
#(
  parameter int CELLS         = DEF_CELLS,
  parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic              Crystal50Mhz1,
  input  logic              ResetLow,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [ADDR_W-1:0] ReqAddr,
  input  logic              ReqData,
  output logic              RespValid,
  input  logic              RespReady,
  output logic              RespData,
  output logic              RespError,
  output logic [CELLS-1:0]  WriteEdge,
  output logic [CELLS-1:0]  ReadEdge,
  output logic              inputData,
  input  logic [CELLS-1:0]  outputData
);

  localparam logic [ADDR_W:0] CELLS_LIM   = (ADDR_W+1)'(CELLS);
  localparam logic [3:0]      STROBE_LOAD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0]      SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_e            r_state;
  state_e            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic              r_write;
  logic [3:0]        r_cnt;
  logic              r_in_data;
  logic              r_resp_data;
  logic              r_resp_err;
  logic              r_ready_en;
  logic              w_accept;
  logic              w_bad_addr;
  logic              w_cnt_done;
  logic              w_we_en;
  logic              w_re_en;
  logic              w_rd_bit;

  // ReqReady stays low while in reset and rises on the first edge afterwards.
  assign ReqReady   = r_ready_en & (r_state == ST_IDLE);
  assign w_accept   = ReqValid & ReqReady;
  assign w_bad_addr = {1'b0, ReqAddr} >= CELLS_LIM;
  assign w_cnt_done = (r_cnt == 4'd0);

  assign RespValid = (r_state == ST_RESP);
  assign RespData  = r_resp_data;
  assign RespError = r_resp_err;
  assign inputData = r_in_data;

  assign w_we_en = (r_state == ST_STROBE) & r_write;
`ifdef ZSRAM_READBACK_VERIFY_EN
  assign w_re_en = ((r_state == ST_STROBE) & ~r_write) | (r_state == ST_VSTROBE);
`else
  assign w_re_en = (r_state == ST_STROBE) & ~r_write;
`endif
  assign w_rd_bit = |(outputData & ReadEdge);

  zsram_edge_decoder #(.CELLS(CELLS)) u_wr_dec (
    .i_addr (r_addr),
    .i_en   (w_we_en),
    .o_edge (WriteEdge)
  );

  zsram_edge_decoder #(.CELLS(CELLS)) u_rd_dec (
    .i_addr (r_addr),
    .i_en   (w_re_en),
    .o_edge (ReadEdge)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next = w_bad_addr ? ST_RESP : ST_SETUP;
      ST_SETUP:  w_next = ST_STROBE;
      ST_STROBE: if (w_cnt_done) w_next = ST_SETTLE;
`ifdef ZSRAM_READBACK_VERIFY_EN
      ST_SETTLE:  if (w_cnt_done) w_next = r_write ? ST_VSTROBE : ST_RESP;
      ST_VSTROBE: if (w_cnt_done) w_next = ST_VSETTLE;
      ST_VSETTLE: if (w_cnt_done) w_next = ST_RESP;
`else
      ST_SETTLE: if (w_cnt_done) w_next = ST_RESP;
`endif
      ST_RESP:   if (RespReady) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Crystal50Mhz1 or negedge ResetLow) begin
    if (!ResetLow) r_state <= ST_IDLE;
    else           r_state <= w_next;
  end

  // Request fields only matter once accepted, so they carry no reset.
  always_ff @(posedge Crystal50Mhz1) begin
    if (w_accept) begin
      r_write <= ReqWrite;
      r_addr  <= ReqAddr;
    end
  end

  always_ff @(posedge Crystal50Mhz1 or negedge ResetLow) begin
    if (!ResetLow) begin
      r_ready_en  <= 1'b0;
      r_cnt       <= 4'd0;
      r_in_data   <= 1'b0;
      r_resp_data <= 1'b0;
      r_resp_err  <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_accept) begin
        r_resp_data <= 1'b0;
        r_resp_err  <= w_bad_addr;
        if (ReqWrite && !w_bad_addr) r_in_data <= ReqData;
      end
      // Counter reloads on entry to a timed state and saturates at zero.
      if (w_next != r_state) begin
        case (w_next)
          ST_STROBE:  r_cnt <= STROBE_LOAD;
          ST_SETTLE:  r_cnt <= SETTLE_LOAD;
`ifdef ZSRAM_READBACK_VERIFY_EN
          ST_VSTROBE: r_cnt <= STROBE_LOAD;
          ST_VSETTLE: r_cnt <= SETTLE_LOAD;
`endif
          default:    r_cnt <= r_cnt;
        endcase
      end else if (!w_cnt_done) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if ((r_state == ST_STROBE) && w_cnt_done && !r_write) r_resp_data <= w_rd_bit;
`ifdef ZSRAM_READBACK_VERIFY_EN
      if ((r_state == ST_VSTROBE) && w_cnt_done) r_resp_err <= w_rd_bit ^ r_in_data;
`endif
    end
  end

endmodule

// File: tb/tb_zsram_edge_sequencer.sv
// Randomized self-checking bench for zsram_edge_sequencer against a timeline model.
// Honours ZSRAM_READBACK_VERIFY_EN when the design is built with it.
module tb_zsram_edge_sequencer;

  localparam int CELLS = 12;
  localparam int S     = 2;
  localparam int T     = 1;

  logic             clk = 1'b0;
  logic             ResetLow;
  logic             ReqValid;
  logic             ReqReady;
  logic             ReqWrite;
  logic [3:0]       ReqAddr;
  logic             ReqData;
  logic             RespValid;
  logic             RespReady;
  logic             RespData;
  logic             RespError;
  logic [CELLS-1:0] WriteEdge;
  logic [CELLS-1:0] ReadEdge;
  logic             inputData;
  logic [CELLS-1:0] outputData;

  int   n_total = 0;
  int   n_bad   = 0;
  logic model_in;

  always #5 clk = ~clk;

  zsram_edge_sequencer #(
    .CELLS(CELLS), .STROBE_CYCLES(S), .SETTLE_CYCLES(T)
  ) dut (
    .Crystal50Mhz1 (clk),
    .ResetLow      (ResetLow),
    .ReqValid      (ReqValid),
    .ReqReady      (ReqReady),
    .ReqWrite      (ReqWrite),
    .ReqAddr       (ReqAddr),
    .ReqData       (ReqData),
    .RespValid     (RespValid),
    .RespReady     (RespReady),
    .RespData      (RespData),
    .RespError     (RespError),
    .WriteEdge     (WriteEdge),
    .ReadEdge      (ReadEdge),
    .inputData     (inputData),
    .outputData    (outputData)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge with the sequencer idle; returns at a negedge with it idle again.
  task automatic run_txn(input logic wr, input logic [3:0] addr, input logic d,
                         input logic [CELLS-1:0] od, input int hold, input logic extra_req);
    logic             bad;
    logic [CELLS-1:0] onehot;
    logic [CELLS-1:0] ew;
    logic [CELLS-1:0] er;
    logic             exp_rd;
    logic             exp_err;
    int               lat;
    bad        = (addr >= 4'(CELLS));
    outputData = od;
    onehot     = '0;
    exp_rd     = 1'b0;
    exp_err    = bad;
    lat        = bad ? 1 : 2 + S + T;
    if (!bad) begin
      onehot = CELLS'(1) << addr;
      if (!wr) exp_rd = od[addr];
`ifdef ZSRAM_READBACK_VERIFY_EN
      if (wr) begin
        lat     = lat + S + T;
        exp_err = (od[addr] != d);
      end
`endif
    end

    check_val("ready_idle", 32'(ReqReady), 32'd1);
    check_val("din_idle", 32'(inputData), 32'(model_in));
    ReqValid = 1'b1;
    ReqWrite = wr;
    ReqAddr  = addr;
    ReqData  = d;
    if (wr && !bad) model_in = d;
    @(negedge clk);
    ReqValid = 1'b0;

    for (int k = 1; k < lat; k++) begin
      ew = '0;
      er = '0;
      if (!bad && k >= 2 && k <= 1 + S) begin
        if (wr) ew = onehot;
        else    er = onehot;
      end
`ifdef ZSRAM_READBACK_VERIFY_EN
      if (!bad && wr && k >= 2 + S + T && k <= 1 + 2 * S + T) er = onehot;
`endif
      check_val("edges", 32'({WriteEdge, ReadEdge}), 32'({ew, er}));
      check_val("early_resp", 32'(RespValid), 32'd0);
      check_val("busy_ready", 32'(ReqReady), 32'd0);
      check_val("din_busy", 32'(inputData), 32'(model_in));
      @(negedge clk);
    end

    check_val("resp_valid", 32'(RespValid), 32'd1);
    check_val("resp_data", 32'(RespData), 32'(exp_rd));
    check_val("resp_err", 32'(RespError), 32'(exp_err));
    check_val("resp_edges", 32'({WriteEdge, ReadEdge}), 32'd0);
    if (extra_req) begin
      ReqValid = 1'b1;
      ReqWrite = 1'($urandom);
      ReqAddr  = 4'($urandom);
      ReqData  = 1'($urandom);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_val("hold_valid", 32'(RespValid), 32'd1);
      check_val("hold_data", 32'(RespData), 32'(exp_rd));
      check_val("hold_err", 32'(RespError), 32'(exp_err));
      check_val("hold_ready", 32'(ReqReady), 32'd0);
      check_val("hold_edges", 32'({WriteEdge, ReadEdge}), 32'd0);
    end
    RespReady = 1'b1;
    ReqValid  = 1'b0;
    @(negedge clk);
    RespReady = 1'b0;
    check_val("post_valid", 32'(RespValid), 32'd0);
    check_val("post_ready", 32'(ReqReady), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    ResetLow   = 1'b0;
    ReqValid   = 1'b0;
    ReqWrite   = 1'b0;
    ReqAddr    = 4'd0;
    ReqData    = 1'b0;
    RespReady  = 1'b0;
    outputData = '0;
    model_in   = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_ready", 32'(ReqReady), 32'd0);
    check_val("rst_valid", 32'(RespValid), 32'd0);
    check_val("rst_edges", 32'({WriteEdge, ReadEdge}), 32'd0);
    check_val("rst_din", 32'(inputData), 32'd0);
    check_val("rst_resp", 32'({RespData, RespError}), 32'd0);
    ResetLow = 1'b1;
    @(negedge clk);
    check_val("ready_after_rst", 32'(ReqReady), 32'd1);

    run_txn(1'b1, 4'd3, 1'b1, '0, 0, 1'b0);
    run_txn(1'b0, 4'd3, 1'b0, CELLS'(12'h008), 0, 1'b0);
    run_txn(1'b0, 4'd3, 1'b0, CELLS'(12'hff7), 0, 1'b0);
    run_txn(1'b1, 4'd13, 1'b1, CELLS'(12'hfff), 0, 1'b0);
    run_txn(1'b0, 4'd7, 1'b0, CELLS'(12'h080), 10, 1'b1);
    run_txn(1'b1, 4'd5, 1'b1, CELLS'(12'hfdf), 0, 1'b0);
    run_txn(1'b1, 4'd11, 1'b0, CELLS'(12'h800), 2, 1'b1);

    // Reset pulse landing in the middle of a write strobe.
    ReqValid = 1'b1;
    ReqWrite = 1'b1;
    ReqAddr  = 4'd5;
    ReqData  = 1'b1;
    @(negedge clk);
    ReqValid = 1'b0;
    @(negedge clk);
    check_val("abort_strobe", 32'(WriteEdge), 32'(CELLS'(1) << 5));
    #2 ResetLow = 1'b0;
    #1;
    check_val("abort_edges", 32'({WriteEdge, ReadEdge}), 32'd0);
    check_val("abort_din", 32'(inputData), 32'd0);
    check_val("abort_ready", 32'(ReqReady), 32'd0);
    @(negedge clk);
    ResetLow = 1'b1;
    model_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_val("abort_no_resp", 32'(RespValid), 32'd0);
      check_val("abort_rdy", 32'(ReqReady), 32'd1);
    end
    run_txn(1'b1, 4'd5, 1'b1, '0, 1, 1'b0);

    for (int n = 0; n < 60; n++) begin
      run_txn(1'($urandom), 4'($urandom), 1'($urandom), CELLS'($urandom),
              int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
